// File: rtl/zombie_spawner.sv
// Zombie spawn sequencer: waits a level-dependent number of video frames,
// draws a random spawn position/variant, and hands the request to the slot
// allocator over a valid/ready handshake. Tracks live zombies and difficulty.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | game not running; frame counter loaded on Start
// COUNT | counting frame ticks down to 0; waits here while all slots are full
// DRAW  | one cycle: latch spawn payload from Rand_num
// REQ   | spawn_valid high, payload frozen until spawn_ready
module zombie_spawner #(
    parameter int MAX_ZOMBIES   = 8,
    parameter int BASE_INTERVAL = 120,
    parameter int MIN_INTERVAL  = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       frame_tick,
    input  logic [7:0] Rand_num,
    input  logic       zombie_killed,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [9:0] spawn_x,
    output logic       spawn_side,
    output logic [1:0] spawn_type,
    output logic [3:0] active_count,
    output logic [2:0] level
);

    localparam int CNT_W = (BASE_INTERVAL > 1) ? $clog2(BASE_INTERVAL + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DRAW  = 2'd2,
        REQ   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] frame_cnt;
    logic [2:0]       accepted;
    logic [2:0]       level_nxt;
    logic             handshake;
    logic             full;

    // Spawn spacing shrinks by 12 frames per level but never below the floor.
    function automatic logic [CNT_W-1:0] interval(input logic [2:0] lvl);
        int raw;
        raw = BASE_INTERVAL - 12 * int'(lvl);
        if (raw < MIN_INTERVAL) begin
            raw = MIN_INTERVAL;
        end
        return raw[CNT_W-1:0];
    endfunction

    // A request abandoned by Start=0 or Reset does not count as accepted.
    assign handshake = (state == REQ) && spawn_ready && Start;
    assign full      = (active_count >= 4'(MAX_ZOMBIES));
    // Level after this cycle's handshake; the reload must already see it.
    assign level_nxt = (accepted == 3'd7 && level != 3'd7) ? level + 3'd1 : level;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; dropping Start always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (!Start) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = COUNT;
                COUNT:   if (frame_cnt == '0 && !full) state_nxt = DRAW;
                DRAW:    state_nxt = REQ;
                REQ:     if (spawn_ready) state_nxt = COUNT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Request strobe is a pure decode of the REQ state.
    always_comb begin
        spawn_valid = (state == REQ);
    end

    // Frame down-counter: reload on start and on every accepted spawn, hold at 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt <= CNT_W'(BASE_INTERVAL);
        end else if (Start && state == IDLE) begin
            frame_cnt <= interval(level);
        end else if (handshake) begin
            frame_cnt <= interval(level_nxt);
        end else if (Start && state == COUNT && frame_tick && frame_cnt != '0) begin
            frame_cnt <= frame_cnt - CNT_W'(1);
        end
    end

    // Payload is captured once in DRAW and frozen through REQ.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            spawn_x    <= 10'd0;
            spawn_side <= 1'b0;
            spawn_type <= 2'd0;
        end else if (state == DRAW) begin
            spawn_x    <= 10'd64 + {1'b0, Rand_num, 1'b0};
            spawn_side <= Rand_num[7];
            spawn_type <= Rand_num[1:0];
        end
    end

    // Live-zombie and difficulty bookkeeping; a spawn and a kill together cancel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            active_count <= 4'd0;
            level        <= 3'd0;
            accepted     <= 3'd0;
        end else begin
            if (handshake) begin
                accepted <= accepted + 3'd1;
                level    <= level_nxt;
            end
            if (handshake && !zombie_killed) begin
                active_count <= active_count + 4'd1;
            end else if (!handshake && zombie_killed && active_count != 4'd0) begin
                active_count <= active_count - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_zombie_spawner.sv
// Randomized bench for zombie_spawner: stimulus queues the expected payload of
// each spawn, a negedge monitor tracks live count, level and frame spacing at
// the game-rule level and compares whenever the spawner presents a request.
module tb_zombie_spawner;

    localparam int MAX_Z = 8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       frame_tick;
    logic [7:0] Rand_num;
    logic       zombie_killed;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [9:0] spawn_x;
    logic       spawn_side;
    logic [1:0] spawn_type;
    logic [3:0] active_count;
    logic [2:0] level;

    zombie_spawner #(
        .MAX_ZOMBIES  (MAX_Z),
        .BASE_INTERVAL(120),
        .MIN_INTERVAL (30)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .frame_tick   (frame_tick),
        .Rand_num     (Rand_num),
        .zombie_killed(zombie_killed),
        .spawn_ready  (spawn_ready),
        .spawn_valid  (spawn_valid),
        .spawn_x      (spawn_x),
        .spawn_side   (spawn_side),
        .spawn_type   (spawn_type),
        .active_count (active_count),
        .level        (level)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int x;
        int side;
        int typ;
    } spawn_t;

    spawn_t exp_q[$];
    int     vectors       = 0;
    int     miscompares   = 0;
    int     timeouts      = 0;
    int     timeouts_seen = 0;
    int     kill_pct      = 0;
    logic   force_kill    = 1'b0;
    int     intv_tab[8]   = '{120, 108, 96, 84, 72, 60, 48, 36};

    // Reference state: game rules only, no knowledge of the spawner's internals.
    int     m_active  = 0;
    int     m_level   = 0;
    int     m_acc     = 0;
    bit     m_idle    = 1'b1;
    bit     m_episode = 1'b0;
    int     m_ticks   = 0;
    int     m_exp_int = 0;
    bit     m_int_ok  = 1'b0;
    int     wait_cyc  = -1;
    bit     rst_chk   = 1'b0;
    spawn_t held;

    // One frame tick every fourth clock.
    initial begin
        frame_tick = 1'b0;
        forever begin
            repeat (3) @(posedge Clk);
            #1 frame_tick = 1'b1;
            @(posedge Clk);
            #1 frame_tick = 1'b0;
        end
    end

    // Kill pulses: random background rate plus forced pulses from the stimulus.
    initial begin
        zombie_killed = 1'b0;
        forever begin
            @(posedge Clk);
            #2;
            zombie_killed = force_kill ||
                            (kill_pct > 0 && int'($urandom_range(99)) < kill_pct);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor and reference model, evaluated mid-cycle before each posedge.
    always @(negedge Clk) begin
        bit hs;
        bit counting;
        spawn_t e;

        if (timeouts != timeouts_seen) begin
            chk("wait_timeout", timeouts, timeouts_seen);
            timeouts_seen = timeouts;
        end

        chk("active_count", int'(active_count), m_active);
        chk("level", int'(level), m_level);
        if (rst_chk) begin
            chk("reset_x", int'(spawn_x), 0);
            chk("reset_side", int'(spawn_side), 0);
            chk("reset_type", int'(spawn_type), 0);
            chk("reset_valid", int'(spawn_valid), 0);
            rst_chk = 1'b0;
        end
        if (m_idle) begin
            chk("valid_in_idle", int'(spawn_valid), 0);
        end

        if (wait_cyc >= 0) wait_cyc++;

        if (spawn_valid && !m_episode) begin
            chk("spawn_when_full", int'(m_active >= MAX_Z), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_spawn", 1, 0);
                held = '{x: int'(spawn_x), side: int'(spawn_side), typ: int'(spawn_type)};
            end else begin
                e = exp_q.pop_front();
                chk("spawn_x", int'(spawn_x), e.x);
                chk("spawn_side", int'(spawn_side), e.side);
                chk("spawn_type", int'(spawn_type), e.typ);
                held = e;
            end
            if (m_int_ok) chk("interval_ticks", m_ticks, m_exp_int);
            if (wait_cyc >= 0) begin
                chk("kill_to_valid_clk", wait_cyc - 1, 2);
                wait_cyc = -1;
            end
            m_episode = 1'b1;
        end else if (spawn_valid && m_episode) begin
            chk("hold_x", int'(spawn_x), held.x);
            chk("hold_side", int'(spawn_side), held.side);
            chk("hold_type", int'(spawn_type), held.typ);
        end else if (!spawn_valid && m_episode) begin
            chk("valid_dropped_early", 0, 1);
            m_episode = 1'b0;
        end

        if (wait_cyc > 3) begin
            chk("kill_to_valid_clk", wait_cyc - 1, 2);
            wait_cyc = -1;
        end

        // Effect of the coming posedge.
        if (Reset) begin
            m_active  = 0;
            m_level   = 0;
            m_acc     = 0;
            m_idle    = 1'b1;
            m_episode = 1'b0;
            m_int_ok  = 1'b0;
            wait_cyc  = -1;
            rst_chk   = 1'b1;
        end else begin
            hs       = m_episode && spawn_ready && Start;
            counting = !m_idle && !m_episode;
            if (counting && m_ticks >= m_exp_int && m_active >= MAX_Z) begin
                m_int_ok = 1'b0;
                if (zombie_killed) wait_cyc = 0;
            end
            if (counting && frame_tick) m_ticks++;
            if (hs) begin
                m_acc = (m_acc + 1) % 8;
                if (m_acc == 0 && m_level < 7) m_level++;
            end
            if (hs && !zombie_killed) m_active++;
            else if (!hs && zombie_killed && m_active > 0) m_active--;
            if (!Start) begin
                m_idle    = 1'b1;
                m_episode = 1'b0;
            end else if (m_idle || hs) begin
                m_idle    = 1'b0;
                m_episode = 1'b0;
                m_ticks   = 0;
                m_exp_int = intv_tab[m_level];
                m_int_ok  = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (spawn_valid) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (!ok) begin
            timeouts++;
            $display("FAIL spawn_valid_wait: got no request, expected one within 3000 clocks");
        end
    endtask

    // mode 0: normal handshake, 1: drop Start in REQ, 2: Reset in REQ with ready high.
    task automatic do_spawn(input int r, input int stall, input bit kill_on_hs,
                            input int mode, input int blocked_wait);
        spawn_t e;
        bit ok;
        Rand_num = 8'(r);
        e.x    = 64 + 2 * r;
        e.side = r / 128;
        e.typ  = r % 4;
        exp_q.push_back(e);
        if (blocked_wait > 0) begin
            repeat (blocked_wait) cyc();
            force_kill = 1'b1;
            cyc();
            force_kill = 1'b0;
        end
        wait_valid(ok);
        if (!ok) return;
        for (int i = 0; i < stall; i++) begin
            Rand_num = 8'($urandom);
            cyc();
        end
        case (mode)
            1: begin
                Start = 1'b0;
                cyc();
                Start = 1'b1;
            end
            2: begin
                Reset       = 1'b1;
                spawn_ready = 1'b1;
                cyc();
                Reset       = 1'b0;
                spawn_ready = 1'b0;
            end
            default: begin
                spawn_ready = 1'b1;
                force_kill  = kill_on_hs;
                cyc();
                spawn_ready = 1'b0;
                force_kill  = 1'b0;
            end
        endcase
    endtask

    initial begin
        Reset       = 1'b1;
        Start       = 1'b0;
        spawn_ready = 1'b0;
        Rand_num    = 8'd0;
        repeat (3) cyc();
        Reset = 1'b0;
        cyc();
        Start = 1'b1;

        do_spawn(101, 0, 1'b0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            do_spawn(int'($urandom_range(255)), int'($urandom_range(20)), 1'b0, 0, 0);
        end
        do_spawn(int'($urandom_range(255)), 2, 1'b0, 0, 600);

        kill_pct = 30;
        for (int i = 0; i < 60; i++) begin
            do_spawn(int'($urandom_range(255)), int'($urandom_range(3)),
                     1'($urandom_range(1)), 0, 0);
        end

        do_spawn(int'($urandom_range(255)), 3, 1'b0, 1, 0);
        do_spawn(int'($urandom_range(255)), 1, 1'b1, 0, 0);
        do_spawn(int'($urandom_range(255)), 2, 1'b0, 2, 0);

        repeat (5) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
